// File: rtl/jam_cost_server.sv
// Cost-table responder for the JAM search engine: loads an 8x8 cost matrix, serves W/J lookups, then checks the result.
// Latency: Cost is registered, one cycle after W/J; Done/Pass one cycle after Valid; Done/Timeout on the timeout edge itself.
// Backpressure: ld_ready is high only in LOAD, one entry per cycle; ld_valid is ignored once all 64 entries are taken.
//
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   ld_valid/ld_data/ld_ready   row-major table load handshake (W major, J minor)
//   exp_we/exp_cost/exp_count   expected MinCost/MatchCount, writable in LOAD and SERVE
//   DUT_RST                     engine reset, high while loading
//   W, J -> Cost                table lookup for the engine
//   Valid/MinCost/MatchCount    engine result
//   Done/Pass/Timeout/cycles    check outcome and SERVE cycle count
//   CovOk                       all 64 entries were read (tied high unless JAM_SRV_COVERAGE_EN)
// Optional build macro: JAM_SRV_COVERAGE_EN adds the lookup-coverage bitmap and makes Pass depend on it.

module jam_cost_server #(
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ld_valid,
    input  logic [6:0]  ld_data,
    output logic        ld_ready,
    input  logic        exp_we,
    input  logic [9:0]  exp_cost,
    input  logic [3:0]  exp_count,
    output logic        DUT_RST,
    input  logic [2:0]  W,
    input  logic [2:0]  J,
    output logic [6:0]  Cost,
    input  logic        Valid,
    input  logic [9:0]  MinCost,
    input  logic [3:0]  MatchCount,
    output logic        Done,
    output logic        Pass,
    output logic        Timeout,
    output logic [19:0] cycles,
    output logic        CovOk
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SERVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [6:0]  r_table [0:63];
    logic [5:0]  r_addr;
    logic [6:0]  r_cost;
    logic [19:0] r_cycles;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;
    logic [9:0]  r_exp_cost;
    logic [3:0]  r_exp_count;
    logic [9:0]  r_min_cost;
    logic [3:0]  r_match_count;

    logic        w_accept;
    logic        w_timeout_hit;
    logic        w_values_ok;
    logic        w_cov_ok;
    logic        w_ld_ready;
    logic        w_dut_rst;

    assign w_accept      = (r_state == S_LOAD) && ld_valid;
    // Compared before the increment, so the DONE edge is the TIMEOUT-th SERVE edge.
    assign w_timeout_hit = (r_cycles == (TIMEOUT - 20'd1));
    assign w_values_ok   = (r_min_cost == r_exp_cost) && (r_match_count == r_exp_count);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        w_ld_ready = 1'b0;
        w_dut_rst  = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_ld_ready = 1'b1;
                w_dut_rst  = 1'b1;
                if (w_accept && (r_addr == 6'd63)) begin
                    w_next = S_SERVE;
                end
            end
            S_SERVE: begin
                // Valid has priority over a coincident timeout.
                if (Valid) begin
                    w_next = S_CHECK;
                end else if (w_timeout_hit) begin
                    w_next = S_DONE;
                end
            end
            S_CHECK: w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_LOAD;
        endcase
    end

    // Cost table: deliberately not reset, every reset is followed by a full reload.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_table[r_addr] <= ld_data;
        end
    end

`ifdef JAM_SRV_COVERAGE_EN
    logic [63:0] r_touched;
    logic        r_cov_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_touched <= 64'd0;
            r_cov_ok  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD:  r_touched <= 64'd0;
                S_SERVE: r_touched[{W, J}] <= 1'b1;
                S_CHECK: r_cov_ok <= &r_touched;
                default: ;
            endcase
        end
    end

    assign w_cov_ok = &r_touched;
    assign CovOk    = r_cov_ok;
`else
    assign w_cov_ok = 1'b1;
    assign CovOk    = 1'b1;
`endif

    // Datapath and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr        <= 6'd0;
            r_cost        <= 7'd0;
            r_cycles      <= 20'd0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_exp_cost    <= 10'd0;
            r_exp_count   <= 4'd0;
            r_min_cost    <= 10'd0;
            r_match_count <= 4'd0;
        end else begin
            if (exp_we && ((r_state == S_LOAD) || (r_state == S_SERVE))) begin
                r_exp_cost  <= exp_cost;
                r_exp_count <= exp_count;
            end
            case (r_state)
                S_LOAD: begin
                    r_cost <= 7'd0;
                    // Address stops at 63: the state leaves LOAD on that accept.
                    if (w_accept && (r_addr != 6'd63)) begin
                        r_addr <= r_addr + 6'd1;
                    end
                end
                S_SERVE: begin
                    r_cost <= r_table[{W, J}];
                    if (r_cycles != 20'hFFFFF) begin
                        r_cycles <= r_cycles + 20'd1;
                    end
                    if (Valid) begin
                        r_min_cost    <= MinCost;
                        r_match_count <= MatchCount;
                    end else if (w_timeout_hit) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    r_pass <= w_values_ok && w_cov_ok;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ld_ready = w_ld_ready;
    assign DUT_RST  = w_dut_rst;
    assign Cost     = r_cost;
    assign cycles   = r_cycles;
    assign Done     = r_done;
    assign Pass     = r_pass;
    assign Timeout  = r_timeout;

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: directed load/serve/check scenarios,
// a behavioural model compared every cycle, plus literal spot checks.
module tb_jam_cost_server;

    localparam logic [19:0] TO = 20'd1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ld_valid = 1'b0;
    logic [6:0]  ld_data = 7'd0;
    logic        ld_ready;
    logic        exp_we = 1'b0;
    logic [9:0]  exp_cost = 10'd0;
    logic [3:0]  exp_count = 4'd0;
    logic        DUT_RST;
    logic [2:0]  W = 3'd0;
    logic [2:0]  J = 3'd0;
    logic [6:0]  Cost;
    logic        Valid = 1'b0;
    logic [9:0]  MinCost = 10'd0;
    logic [3:0]  MatchCount = 4'd0;
    logic        Done;
    logic        Pass;
    logic        Timeout;
    logic [19:0] cycles;
    logic        CovOk;

    int n_cmp = 0;
    int n_bad = 0;

    jam_cost_server #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .exp_we(exp_we), .exp_cost(exp_cost), .exp_count(exp_count),
        .DUT_RST(DUT_RST), .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .Done(Done), .Pass(Pass), .Timeout(Timeout), .cycles(cycles),
        .CovOk(CovOk)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_loading, m_chk, m_fin, m_serving, m_covok, m_cov;
    int          m_addr, m_idx, m_cycles;
    logic [6:0]  m_tab [64];
    logic [6:0]  m_cost;
    bit          m_done, m_pass, m_to;
    logic [9:0]  m_lc, m_ec;
    logic [3:0]  m_ln, m_en;
    logic [63:0] m_touch;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_loading = 1; m_chk = 0; m_fin = 0; m_addr = 0; m_cycles = 0;
            m_cost = 0; m_done = 0; m_pass = 0; m_to = 0;
            m_lc = 0; m_ln = 0; m_ec = 0; m_en = 0; m_touch = 0;
`ifdef JAM_SRV_COVERAGE_EN
            m_covok = 0;
`else
            m_covok = 1;
`endif
        end else begin
            m_serving = !m_loading && !m_chk && !m_fin;
            if (exp_we && (m_loading || m_serving)) begin
                m_ec = exp_cost;
                m_en = exp_count;
            end
            if (m_loading) begin
                m_cost  = 0;
                m_touch = 0;
                if (ld_valid) begin
                    m_tab[m_addr] = ld_data;
                    m_addr++;
                    if (m_addr == 64) m_loading = 0;
                end
            end else if (m_serving) begin
                m_idx = int'(W) * 8 + int'(J);
                m_cost = m_tab[m_idx];
                m_touch[m_idx] = 1'b1;
                if (m_cycles < 20'hFFFFF) m_cycles++;
                if (Valid) begin
                    m_lc = MinCost;
                    m_ln = MatchCount;
                    m_chk = 1;
                end else if (m_cycles == int'(TO)) begin
                    // TO serve cycles elapsed without a result
                    m_done = 1; m_to = 1; m_pass = 0; m_fin = 1;
                end
            end else if (m_chk) begin
`ifdef JAM_SRV_COVERAGE_EN
                m_cov = (m_touch == {64{1'b1}});
                m_covok = m_cov;
`else
                m_cov = 1;
`endif
                m_pass = (m_lc == m_ec) && (m_ln == m_en) && m_cov;
                m_done = 1;
                m_chk = 0;
                m_fin = 1;
            end
        end
    end

    // Every-cycle comparison against the model, 1 time unit after the edge
    always @(posedge CLK) begin
        #1;
        chk("ld_ready", 32'(ld_ready), 32'(m_loading));
        chk("DUT_RST",  32'(DUT_RST),  32'(m_loading));
        chk("Cost",     32'(Cost),     32'(m_cost));
        chk("Done",     32'(Done),     32'(m_done));
        chk("Pass",     32'(Pass),     32'(m_pass));
        chk("Timeout",  32'(Timeout),  32'(m_to));
        chk("cycles",   32'(cycles),   32'(m_cycles));
        chk("CovOk",    32'(CovOk),    32'(m_covok));
    end

    // ---------------- stimulus ----------------
    task automatic start(input logic [9:0] c, input logic [3:0] n);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        exp_we = 1'b1; exp_cost = c; exp_count = n;
        @(negedge CLK);
        exp_we = 1'b0;
    endtask

    // table[w][j] = 8w+j, one entry per cycle
    task automatic load_cont();
        for (int k = 0; k < 64; k++) begin
            ld_valid = 1'b1;
            ld_data  = 7'(k);
            @(negedge CLK);
        end
        ld_valid = 1'b0;
    endtask

    // Reads every entry in the first 64 cycles (optionally never {7,7}), Valid on cycle vat
    task automatic serve(input int n, input int vat, input logic [9:0] mc,
                         input logic [3:0] cnt, input bit skip77);
        for (int s = 1; s <= n; s++) begin
            int idx;
            idx = (s <= 64) ? s - 1 : (s * 5) % 63;
            if (skip77 && idx == 63) idx = 0;
            W = 3'(idx >> 3);
            J = 3'(idx & 7);
            Valid = (s == vat);
            MinCost = mc;
            MatchCount = cnt;
            @(negedge CLK);
        end
        Valid = 1'b0;
    endtask

    initial begin
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_DUT_RST",  32'(DUT_RST),  32'd1);
        chk("rst_Cost",     32'(Cost),     32'd0);
        chk("rst_Done",     32'(Done),     32'd0);
        chk("rst_cycles",   32'(cycles),   32'd0);

        // Continuous load and basic lookups
        start(10'd100, 4'd3);
        load_cont();
        chk("load_ld_ready", 32'(ld_ready), 32'd0);
        chk("load_DUT_RST",  32'(DUT_RST),  32'd0);
        W = 3'd3; J = 3'd5; @(negedge CLK);
        chk("cost_3_5", 32'(Cost), 32'd29);
        W = 3'd7; J = 3'd7; @(negedge CLK);
        chk("cost_7_7", 32'(Cost), 32'd63);
        W = 3'd1; J = 3'd1; @(negedge CLK);

        // Reset mid-SERVE: asynchronous return to LOAD
        RST = 1'b1;
        #1;
        chk("midrst_DUT_RST",  32'(DUT_RST),  32'd1);
        chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
        chk("midrst_Cost",     32'(Cost),     32'd0);
        chk("midrst_Done",     32'(Done),     32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Reload new data with ld_valid toggling; a 65th entry is ignored
        for (int k = 0; k < 64; k++) begin
            ld_valid = 1'b1;
            ld_data  = 7'((k * 3 + 1) & 127);
            @(negedge CLK);
            if (k == 62) chk("tog_ready_before_last", 32'(ld_ready), 32'd1);
            if (k < 63) begin
                ld_valid = 1'b0;
                ld_data  = 7'h55;
                @(negedge CLK);
            end
        end
        chk("tog_ld_ready", 32'(ld_ready), 32'd0);
        chk("tog_DUT_RST",  32'(DUT_RST),  32'd0);
        ld_valid = 1'b1; ld_data = 7'h7F;
        W = 3'd7; J = 3'd7; @(negedge CLK);
        ld_valid = 1'b0;
        chk("new_cost_7_7", 32'(Cost), 32'd62);
        W = 3'd0; J = 3'd0; @(negedge CLK);
        chk("new_cost_0_0", 32'(Cost), 32'd1);
        W = 3'd3; J = 3'd5; @(negedge CLK);
        chk("new_cost_3_5", 32'(Cost), 32'd88);
        W = 3'd7; J = 3'd7; @(negedge CLK);
        chk("new_cost_7_7_again", 32'(Cost), 32'd62);

        // Matching result on SERVE cycle 500
        start(10'd100, 4'd3);
        load_cont();
        serve(500, 500, 10'd100, 4'd3, 1'b0);
        chk("match_done_pre", 32'(Done),   32'd0);
        chk("match_cycles",   32'(cycles), 32'd500);
        @(negedge CLK);
        chk("match_done",   32'(Done),   32'd1);
        chk("match_pass",   32'(Pass),   32'd1);
        chk("match_cycles_frozen", 32'(cycles), 32'd500);
        exp_we = 1'b1; exp_cost = 10'd7; exp_count = 4'd1;
        repeat (3) @(negedge CLK);
        exp_we = 1'b0;
        chk("done_hold_pass",   32'(Pass),   32'd1);
        chk("done_hold_cycles", 32'(cycles), 32'd500);
        chk("done_DUT_RST",     32'(DUT_RST), 32'd0);

        // Wrong MatchCount
        start(10'd100, 4'd3);
        load_cont();
        serve(500, 500, 10'd100, 4'd2, 1'b0);
        @(negedge CLK);
        chk("badcnt_done", 32'(Done), 32'd1);
        chk("badcnt_pass", 32'(Pass), 32'd0);

        // Correct values but entry {7,7} never read
        start(10'd100, 4'd3);
        load_cont();
        serve(500, 500, 10'd100, 4'd3, 1'b1);
        @(negedge CLK);
        chk("skip_done", 32'(Done), 32'd1);
`ifdef JAM_SRV_COVERAGE_EN
        chk("skip_covok", 32'(CovOk), 32'd0);
        chk("skip_pass",  32'(Pass),  32'd0);
`else
        chk("skip_covok", 32'(CovOk), 32'd1);
        chk("skip_pass",  32'(Pass),  32'd1);
`endif

        // Timeout with no Valid
        start(10'd100, 4'd3);
        load_cont();
        serve(999, 0, 10'd0, 4'd0, 1'b0);
        chk("to_done_pre", 32'(Done), 32'd0);
        serve(1, 0, 10'd0, 4'd0, 1'b0);
        chk("to_done",    32'(Done),    32'd1);
        chk("to_timeout", 32'(Timeout), 32'd1);
        chk("to_pass",    32'(Pass),    32'd0);
        chk("to_cycles",  32'(cycles),  32'd1000);
        repeat (2) @(negedge CLK);
        chk("to_cycles_hold", 32'(cycles), 32'd1000);

        // Valid on the timeout edge wins
        start(10'd100, 4'd3);
        load_cont();
        serve(1000, 1000, 10'd100, 4'd3, 1'b0);
        chk("vto_timeout_pre", 32'(Timeout), 32'd0);
        chk("vto_done_pre",    32'(Done),    32'd0);
        @(negedge CLK);
        chk("vto_done",    32'(Done),    32'd1);
        chk("vto_pass",    32'(Pass),    32'd1);
        chk("vto_timeout", 32'(Timeout), 32'd0);
        chk("vto_cycles",  32'(cycles),  32'd1000);

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
